// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: shared write-back, next-pc and load-size encodings.
package ysyx_25020047_pkg;
  typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_MEM, WB_SNPC, WB_CSR} wb_sel_e;
  typedef enum logic [1:0] {PC_SNPC, PC_RESULT, PC_MTVEC} pc_sel_e;
  typedef enum logic [1:0] {MS_BYTE, MS_HALF, MS_WORD} mem_size_e;
endpackage

// File: rtl/ysyx_25020047_wb_fifo.sv
// ysyx_25020047_wb_fifo: retire queue, power-of-two depth, pointers wrap naturally.
module ysyx_25020047_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic w_en, r_en;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  assign w_en  = push & ~full;
  assign r_en  = pop & ~empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(w_en);
      rp  <= rp + AW'(r_en);
      cnt <= cnt + CW'(w_en) - CW'(r_en);
    end
  // Payload needs no reset: it is only observed when the count says it is valid.
  always_ff @(posedge clk)
    if (w_en) mem[wp] <= din;
endmodule

// File: rtl/ysyx_25020047_wb_stage.sv
// ysyx_25020047_wb_stage: write-back stage; WBU_PERF_CNT_EN adds a 64-bit retire counter.
module ysyx_25020047_wb_stage
  import ysyx_25020047_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_wb_sel,
  input  logic [1:0]      in_pc_sel,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_memdata,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [XLEN-1:0] in_mtvec,
  input  logic [XLEN-1:0] in_snpc,
  input  logic [1:0]      in_mem_size,
  input  logic            in_mem_unsigned,
  input  logic [1:0]      in_mem_off,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            npc_valid,
  input  logic            npc_ready,
  output logic [XLEN-1:0] npc
`ifdef WBU_PERF_CNT_EN
  , output logic [63:0]   perf_retired
`endif
);
  localparam int EW = 6 + 2 * XLEN;
  logic [XLEN-1:0] sh, ld, wdata, dnpc, h_wdata, h_dnpc;
  logic [EW-1:0] head;
  logic [4:0] h_rd;
  logic wen, h_wen, sb, shw, full, empty, retire;
  always_comb begin
    sh    = in_memdata >> {in_mem_off, 3'b000};
    sb    = ~in_mem_unsigned & sh[7];
    shw   = ~in_mem_unsigned & sh[15];
    ld    = in_mem_size == MS_BYTE ? {{(XLEN-8){sb}}, sh[7:0]} :
            in_mem_size == MS_HALF ? {{(XLEN-16){shw}}, sh[15:0]} : sh;
    wdata = in_wb_sel == WB_ALU  ? in_result :
            in_wb_sel == WB_MEM  ? ld :
            in_wb_sel == WB_SNPC ? in_snpc :
            in_wb_sel == WB_CSR  ? in_csr_rdata : '0;
    wen   = in_wb_sel inside {WB_ALU, WB_MEM, WB_SNPC, WB_CSR};
    dnpc  = in_pc_sel == PC_RESULT ? in_result :
            in_pc_sel == PC_MTVEC  ? in_mtvec : in_snpc;
  end
  assign in_ready  = ~full;
  assign npc_valid = ~empty;
  assign retire    = npc_valid & npc_ready;
  ysyx_25020047_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid & in_ready),
    .pop  (retire),
    .din  ({wen, in_rd, wdata, dnpc}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign {h_wen, h_rd, h_wdata, h_dnpc} = head;
  assign rf_wen   = retire & h_wen & |h_rd;
  assign rf_waddr = empty ? '0 : h_rd;
  assign rf_wdata = empty ? '0 : h_wdata;
  assign npc      = empty ? '0 : h_dnpc;
`ifdef WBU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_retired <= '0;
    else if (retire) perf_retired <= perf_retired + 64'd1;
`endif
endmodule

// File: tb/tb_ysyx_25020047_wb_stage.sv
// tb_ysyx_25020047_wb_stage: directed self-checking bench for the write-back stage.
module tb_ysyx_25020047_wb_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_mem_unsigned = 0, npc_ready = 0;
  logic [2:0] in_wb_sel = 0;
  logic [1:0] in_pc_sel = 0, in_mem_size = 0, in_mem_off = 0;
  logic [4:0] in_rd = 0, rf_waddr;
  logic [31:0] in_result = 0, in_memdata = 0, in_csr_rdata = 0, in_mtvec = 0, in_snpc = 0;
  logic rf_wen, npc_valid;
  logic [31:0] rf_wdata, npc;
`ifdef WBU_PERF_CNT_EN
  logic [63:0] perf_retired;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_25020047_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_pc_sel(in_pc_sel), .in_rd(in_rd),
    .in_result(in_result), .in_memdata(in_memdata), .in_csr_rdata(in_csr_rdata),
    .in_mtvec(in_mtvec), .in_snpc(in_snpc), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_mem_off(in_mem_off),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .npc_valid(npc_valid), .npc_ready(npc_ready), .npc(npc)
`ifdef WBU_PERF_CNT_EN
    , .perf_retired(perf_retired)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_in(input logic [2:0] ws, input logic [1:0] ps, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] snpc);
    in_wb_sel = ws; in_pc_sel = ps; in_rd = rd; in_result = res; in_snpc = snpc;
  endtask
  task automatic send(input logic [2:0] ws, input logic [1:0] ps, input logic [4:0] rd,
                      input logic [31:0] res, input logic [31:0] snpc);
    set_in(ws, ps, rd, res, snpc);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic load(input logic [1:0] sz, input logic u, input logic [1:0] off, input logic [31:0] md);
    in_mem_size = sz; in_mem_unsigned = u; in_mem_off = off; in_memdata = md;
    send(3'd2, 2'd0, 5'd7, 32'h0, 32'h8000_0010);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_npc_valid"}, npc_valid, 0);
    chk({tag, "_rf_wen"}, rf_wen, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_npc"}, npc, 0);
  endtask
  initial begin
    #12;
    check_reset_outputs("rst");
    rst_n = 1;
    @(negedge clk);
    npc_ready = 1;
    set_in(3'd1, 2'd0, 5'd5, 32'h1234, 32'h8000_0004);
    in_valid = 1;
    #1 chk("no_bypass", npc_valid, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("alu_wen", rf_wen, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_npc", npc, 32'h8000_0004);
    load(2'd0, 0, 2'd3, 32'h80FF_7F00);
    chk("lb_off3", rf_wdata, 32'hFFFF_FF80);
    chk("lb_wen", rf_wen, 1);
    load(2'd0, 1, 2'd3, 32'h80FF_7F00);
    chk("lbu_off3", rf_wdata, 32'h0000_0080);
    load(2'd1, 0, 2'd2, 32'h80FF_7F00);
    chk("lh_off2", rf_wdata, 32'hFFFF_80FF);
    load(2'd1, 1, 2'd0, 32'h80FF_7F00);
    chk("lhu_off0", rf_wdata, 32'h0000_7F00);
    load(2'd0, 0, 2'd1, 32'h80FF_7F00);
    chk("lb_off1_pos", rf_wdata, 32'h0000_007F);
    load(2'd2, 1, 2'd0, 32'h80FF_7F00);
    chk("lw_ign_unsigned", rf_wdata, 32'h80FF_7F00);
    load(2'd3, 0, 2'd0, 32'h1234_5678);
    chk("size3_word", rf_wdata, 32'h1234_5678);
    in_csr_rdata = 32'hCAFE_0001; in_mtvec = 32'h8000_0200;
    send(3'd4, 2'd2, 5'd9, 32'h0, 32'h8000_0020);
    chk("csr_wdata", rf_wdata, 32'hCAFE_0001);
    chk("mtvec_npc", npc, 32'h8000_0200);
    send(3'd1, 2'd3, 5'd4, 32'h9999_0000, 32'h8000_0024);
    chk("pcsel3_snpc", npc, 32'h8000_0024);
    send(3'd5, 2'd0, 5'd6, 32'h5, 32'h8000_0028);
    chk("wbsel5_nowen", rf_wen, 0);
    chk("wbsel5_valid", npc_valid, 1);
    send(3'd0, 2'd0, 5'd6, 32'h5, 32'h8000_002C);
    chk("none_nowen", rf_wen, 0);
    send(3'd3, 2'd1, 5'd0, 32'h8000_0100, 32'h8000_0008);
    chk("rd0_nowen", rf_wen, 0);
    chk("rd0_npc", npc, 32'h8000_0100);
    @(posedge clk); #1;
    chk("drain_empty", npc_valid, 0);
    chk("drain_waddr", rf_waddr, 0);
    npc_ready = 0;
    send(3'd1, 2'd0, 5'd1, 32'h11, 32'h100);
    chk("one_ready", in_ready, 1);
    send(3'd1, 2'd0, 5'd2, 32'h22, 32'h104);
    chk("full_ready", in_ready, 0);
    chk("full_wen", rf_wen, 0);
    chk("full_head", rf_wdata, 32'h11);
    set_in(3'd1, 2'd0, 5'd3, 32'h33, 32'h108);
    in_valid = 1;
    @(posedge clk); #1;
    chk("held_ready", in_ready, 0);
    chk("held_head", rf_waddr, 1);
    npc_ready = 1;
    #1;
    chk("ret_a_wen", rf_wen, 1);
    chk("ret_a_npc", npc, 32'h100);
    @(posedge clk); #1;
    chk("blocked_head_b", rf_waddr, 2);
    chk("blocked_ready", in_ready, 1);
    chk("b_wdata", rf_wdata, 32'h22);
    @(posedge clk); #1;
    in_valid = 0;
    chk("c_waddr", rf_waddr, 3);
    chk("c_wdata", rf_wdata, 32'h33);
    chk("c_npc", npc, 32'h108);
    @(posedge clk); #1;
    chk("fifo_drained", npc_valid, 0);
    npc_ready = 0;
    send(3'd1, 2'd0, 5'd8, 32'h44, 32'h200);
    send(3'd1, 2'd0, 5'd9, 32'h55, 32'h204);
    chk("pre_rst_full", in_ready, 0);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    npc_ready = 1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_valid", npc_valid, 0);
    chk("post_rst_wen", rf_wen, 0);
`ifdef WBU_PERF_CNT_EN
    chk("perf_rst", perf_retired, 0);
    for (int i = 0; i < 10; i++) begin
      send(3'd1, 2'd0, 5'd1, i, 32'h300);
      if (i % 3 == 0 && i < 9) begin
        npc_ready = 0;
        @(posedge clk); #1;
        npc_ready = 1;
      end
    end
    @(posedge clk); #1;
    chk("perf_10", perf_retired, 10);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
